// File: rtl/aspiradora_pkg.sv
// Shared types for the vacuum-cleaner command sequencer: FSM feedback encoding,
// sequencer states and command bit positions.
package aspiradora_pkg;

    typedef enum logic [1:0] {
        FSM_OFF      = 2'd0,
        FSM_ON       = 2'd1,
        FSM_CLEANING = 2'd2,
        FSM_EVADING  = 2'd3
    } fsm_state_t;

    typedef enum logic [1:0] {
        SEQ_IDLE       = 2'd0,
        SEQ_WAIT_ACK   = 2'd1,
        SEQ_HOLD_EVADE = 2'd2,
        SEQ_FAULT      = 2'd3
    } seq_state_t;

    // Command bit positions deliberately equal the FSM state each command targets.
    localparam int CMD_IDX_POWER_OFF = 0;
    localparam int CMD_IDX_ON        = 1;
    localparam int CMD_IDX_CLEANING  = 2;
    localparam int CMD_IDX_EVADING   = 3;

    function automatic logic [3:0] cmd_onehot(input fsm_state_t target);
        return 4'b0001 << target;
    endfunction

endpackage

// File: rtl/aspiradora_debounce.sv
// Two-flop synchroniser plus stable-sample debouncer; output is either the
// debounced level or a one-cycle pulse when that level rises.
module aspiradora_debounce #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter bit PULSE_OUT       = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic out
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt;
    logic             level;
    logic             level_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync    <= '0;
            cnt     <= '0;
            level   <= 1'b0;
            level_d <= 1'b0;
        end else begin
            sync    <= {sync[0], raw};
            level_d <= level;
            // cnt counts consecutive synchronised samples that disagree with level
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level <= sync[1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign out = PULSE_OUT ? (level & ~level_d) : level;

endmodule

// File: rtl/aspiradora_cmd_seq.sv
// Command sequencer feeding the vacuum-cleaner FSM: issues one-hot level commands
// and holds them until acknowledged. Optional macro CMD_SEQ_EVADE_COUNT_EN enables evade_count.
//
// state          | meaning
// SEQ_IDLE       | no command pending, waiting for a button or obstacle event
// SEQ_WAIT_ACK   | command held until state_fb matches target, or timeout
// SEQ_HOLD_EVADE | evade acknowledged, waiting for obstacle to stay clear
// SEQ_FAULT      | acknowledgement timed out; only a power press recovers
module aspiradora_cmd_seq
    import aspiradora_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int ACK_TIMEOUT     = 255,
    parameter int EVADE_HOLD      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_power,
    input  logic       btn_start,
    input  logic       obstacle,
    input  logic [1:0] state_fb,
    output logic       cmd_power_off,
    output logic       cmd_on,
    output logic       cmd_cleaning,
    output logic       cmd_evading,
    output logic       busy,
    output logic       fault,
    output logic [7:0] evade_count
);
    localparam int TIMER_W = $clog2(ACK_TIMEOUT + 1);
    localparam int HOLD_W  = $clog2(EVADE_HOLD + 1);

    logic power_rise;
    logic start_rise;
    logic obs_level;

    aspiradora_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .PULSE_OUT(1'b1)) u_db_power (
        .clk(clk), .rst(rst), .raw(btn_power), .out(power_rise)
    );
    aspiradora_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .PULSE_OUT(1'b1)) u_db_start (
        .clk(clk), .rst(rst), .raw(btn_start), .out(start_rise)
    );
    aspiradora_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .PULSE_OUT(1'b0)) u_db_obstacle (
        .clk(clk), .rst(rst), .raw(obstacle), .out(obs_level)
    );

    seq_state_t         state, state_nxt;
    fsm_state_t         target, target_nxt;
    fsm_state_t         fb;
    logic [TIMER_W-1:0] timer, timer_nxt;
    logic [HOLD_W-1:0]  hold_cnt, hold_nxt;
    logic [3:0]         cmd, cmd_nxt;
    logic               fault_nxt;
    logic               issue;
    fsm_state_t         issue_tgt;

    assign fb = fsm_state_t'(state_fb);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= SEQ_IDLE;
            target   <= FSM_OFF;
            timer    <= '0;
            hold_cnt <= '0;
            cmd      <= '0;
            busy     <= 1'b0;
            fault    <= 1'b0;
        end else begin
            state    <= state_nxt;
            target   <= target_nxt;
            timer    <= timer_nxt;
            hold_cnt <= hold_nxt;
            cmd      <= cmd_nxt;
            busy     <= |cmd_nxt;
            fault    <= fault_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        target_nxt = target;
        timer_nxt  = timer;
        hold_nxt   = hold_cnt;
        cmd_nxt    = '0;
        fault_nxt  = fault;
        issue      = 1'b0;
        issue_tgt  = FSM_OFF;

        case (state)
            SEQ_IDLE: begin
                if (power_rise) begin
                    issue     = 1'b1;
                    issue_tgt = (fb == FSM_OFF) ? FSM_ON : FSM_OFF;
                end else if (obs_level && fb == FSM_CLEANING) begin
                    issue     = 1'b1;
                    issue_tgt = FSM_EVADING;
                end else if (start_rise && fb == FSM_ON) begin
                    issue     = 1'b1;
                    issue_tgt = FSM_CLEANING;
                end
            end
            SEQ_WAIT_ACK: begin
                // A power press swaps the held command in the same edge, keeping one-hot.
                if (power_rise) begin
                    issue     = 1'b1;
                    issue_tgt = FSM_OFF;
                end else if (fb == target) begin
                    state_nxt = (target == FSM_EVADING) ? SEQ_HOLD_EVADE : SEQ_IDLE;
                    hold_nxt  = '0;
                end else if (timer == TIMER_W'(ACK_TIMEOUT - 1)) begin
                    state_nxt = SEQ_FAULT;
                    fault_nxt = 1'b1;
                end else begin
                    timer_nxt = timer + TIMER_W'(1);
                    cmd_nxt   = cmd_onehot(target);
                end
            end
            SEQ_HOLD_EVADE: begin
                if (power_rise) begin
                    issue     = 1'b1;
                    issue_tgt = FSM_OFF;
                end else if (obs_level) begin
                    hold_nxt = '0;
                end else if (hold_cnt == HOLD_W'(EVADE_HOLD - 1)) begin
                    issue     = 1'b1;
                    issue_tgt = FSM_CLEANING;
                end else begin
                    hold_nxt = hold_cnt + HOLD_W'(1);
                end
            end
            SEQ_FAULT: begin
                if (power_rise) begin
                    issue     = 1'b1;
                    issue_tgt = FSM_OFF;
                    fault_nxt = 1'b0;
                end
            end
            default: state_nxt = SEQ_IDLE;
        endcase

        if (issue) begin
            state_nxt  = SEQ_WAIT_ACK;
            target_nxt = issue_tgt;
            timer_nxt  = '0;
            cmd_nxt    = cmd_onehot(issue_tgt);
        end
    end

    assign cmd_power_off = cmd[CMD_IDX_POWER_OFF];
    assign cmd_on        = cmd[CMD_IDX_ON];
    assign cmd_cleaning  = cmd[CMD_IDX_CLEANING];
    assign cmd_evading   = cmd[CMD_IDX_EVADING];

`ifdef CMD_SEQ_EVADE_COUNT_EN
    logic [7:0] evade_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            evade_cnt <= '0;
        end else if (cmd_nxt[CMD_IDX_EVADING] && !cmd[CMD_IDX_EVADING] && evade_cnt != 8'hFF) begin
            evade_cnt <= evade_cnt + 8'd1;
        end
    end

    assign evade_count = evade_cnt;
`else
    assign evade_count = 8'd0;
`endif

endmodule
